prefetch_issue_queue: RTL
=========================

// Module: prefetch_issue_queue
// PURPOSE
//  Downstream stage of best_offset_prefetcher. Buffers its prefetch requests
//  (lo_prefetch_address_o/valid_o) in a small FIFO and drops duplicate lines.
//  Issues requests to the lower-level cache over a valid/ready handshake.
//  Throttles issue by the number of prefetches still outstanding.
// PARAMETERS
//  WIDTH            64  address width
//  DEPTH            8   FIFO entries (power of 2, >=2)
//  LOGLINE          6   log2 line size; dedup compares addr[WIDTH-1:LOGLINE]
//  MAX_OUTSTANDING  4   max issued-but-unanswered prefetches (>=1)
// PORTS
//  clk              in   1                        clock
//  rst              in   1                        async reset, active-low
//  pf_address_i     in   WIDTH                    prefetch address from the prefetcher
//  pf_valid_i       in   1                        prefetch request valid (no ready; droppable)
//  flush_i          in   1                        discard all queued entries
//  lo_ready_i       in   1                        lower level accepts request
//  lo_resp_valid_i  in   1                        one outstanding prefetch completed
//  lo_address_o     out  WIDTH                    issued address, line-aligned
//  lo_valid_o       out  1                        issue request valid
//  drop_full_o      out  1                        pulse: request dropped, FIFO full
//  drop_dup_o       out  1                        pulse: request dropped, duplicate line
//  occupancy_o      out  $clog2(DEPTH+1)          valid FIFO entries
//  outstanding_o    out  $clog2(MAX_OUTSTANDING+1) outstanding prefetches
// BEHAVIOUR
//  Reset (rst==0, async): FIFO empty, head=tail=0, all outputs 0.
//  Storage: DEPTH x {line addr, valid}, circular; head/tail wrap DEPTH-1 -> 0.
//  Enqueue, evaluated at posedge with pf_valid_i=1, in priority order:
//   1. flush_i=1: request ignored, no drop pulse.
//   2. Line matches any valid entry (head included): drop, drop_dup_o=1 next cycle.
//   3. occupancy_o==DEPTH: drop, drop_full_o=1 next cycle. The full check uses the
//      registered count; a same-cycle pop does not free room.
//   4. Otherwise: write {line,1} at tail, tail++.
//  Dedup covers only queued entries, not issued or outstanding lines.
//  Issue: lo_valid_o = (occupancy_o!=0) && (outstanding_o<MAX_OUTSTANDING) && !flush_i.
//   lo_address_o = {head line, LOGLINE'b0}, driven from registers only.
//   Min latency: accepted at edge N -> lo_valid_o high after edge N.
//   Pop at posedge when lo_valid_o && lo_ready_i: head++, outstanding_o++.
//   While lo_valid_o=1 and not accepted, lo_address_o holds stable.
//   flush_i is the only exception: it may drop lo_valid_o before acceptance.
//  Outstanding counter:
//   +1 on issue; -1 on lo_resp_valid_i; both in one cycle -> unchanged.
//   Response while 0: ignored, counter stays 0.
//   Counter saturates at MAX_OUTSTANDING; issue is blocked there.
//  Simultaneous push+pop with 0<occupancy<DEPTH: occupancy unchanged.
//  Push to empty FIFO: entry is not issued in the same cycle.
//  Flush: at posedge all entries invalid, head=tail=0, occupancy_o=0.
//   outstanding_o is unaffected by flush.
//  drop_*_o are single-cycle registered pulses, never high together.
//  Reset asserted mid-transfer: state clears immediately; no request is replayed.
// TESTING
//  T1 reset, push 0x1040 -> next cycle lo_valid_o=1, lo_address_o=0x1040; ready=1 -> outstanding_o=1.
//  T2 push 0x2000 then 0x2010, lo_ready_i=0 -> second gets drop_dup_o=1, occupancy_o=1.
//  T3 lo_ready_i=0, push 9 distinct lines -> 9th gets drop_full_o=1, occupancy_o=8.
//     Drain 8 with ready=1 -> addresses come out FIFO order; head wraps correctly.
//  T4 MAX_OUTSTANDING=4, 6 queued, ready=1, no resp -> 4 issued, lo_valid_o=0.
//     One lo_resp_valid_i -> exactly 1 more issued.
//  T5 push and pop in the same cycle at occupancy 3 -> occupancy_o stays 3.
//     resp+issue same cycle -> outstanding_o unchanged.
//  T6 flush_i with 5 queued and 2 outstanding -> occupancy_o=0, outstanding_o=2.
//     rst=0 pulse mid-handshake -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/prefetch_issue_queue_if.sv
// Handshake bundle between the prefetcher, the issue queue and the lower-level cache.
// The queue connects through the slave modport; the driving side uses master.
interface prefetch_issue_queue_if #(
    parameter int WIDTH           = 64,
    parameter int DEPTH           = 8,
    parameter int MAX_OUTSTANDING = 4
);
    logic [WIDTH-1:0]                       pf_address_i;
    logic                                   pf_valid_i;
    logic                                   flush_i;
    logic                                   lo_ready_i;
    logic                                   lo_resp_valid_i;
    logic [WIDTH-1:0]                       lo_address_o;
    logic                                   lo_valid_o;
    logic                                   drop_full_o;
    logic                                   drop_dup_o;
    logic [$clog2(DEPTH+1)-1:0]             occupancy_o;
    logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o;

    modport slave (
        input  pf_address_i, pf_valid_i, flush_i, lo_ready_i, lo_resp_valid_i,
        output lo_address_o, lo_valid_o, drop_full_o, drop_dup_o, occupancy_o, outstanding_o
    );

    modport master (
        output pf_address_i, pf_valid_i, flush_i, lo_ready_i, lo_resp_valid_i,
        input  lo_address_o, lo_valid_o, drop_full_o, drop_dup_o, occupancy_o, outstanding_o
    );
endinterface

// File: rtl/prefetch_issue_queue.sv
// Circular prefetch FIFO with line-granular dedup against queued entries,
// valid/ready issue to the lower level and an outstanding-request throttle.
module prefetch_issue_queue #(
    parameter int WIDTH           = 64,
    parameter int DEPTH           = 8,
    parameter int LOGLINE         = 6,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    prefetch_issue_queue_if.slave bus
);
    localparam int LW = WIDTH - LOGLINE;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [OW-1:0] MAX_OUT  = OW'(MAX_OUTSTANDING);

    logic [LW-1:0]    r_line [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [OW-1:0]    r_outstanding;
    logic             r_drop_dup;
    logic             r_drop_full;

    logic [LW-1:0]    w_in_line;
    logic [DEPTH-1:0] w_match;
    logic             w_dup;
    logic             w_full;
    logic             w_req;
    logic             w_push;
    logic             w_issue;
    logic             w_pop;
    logic             w_resp;

    assign w_in_line = bus.pf_address_i[WIDTH-1:LOGLINE];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_match[gi] = r_valid[gi] && (r_line[gi] == w_in_line);
        end
    endgenerate

    // Full check uses the registered count, so a same-cycle pop never makes room.
    assign w_dup   = |w_match;
    assign w_full  = (r_count == FULL_CNT);
    assign w_req   = bus.pf_valid_i && !bus.flush_i;
    assign w_push  = w_req && !w_dup && !w_full;
    assign w_issue = (r_count != '0) && (r_outstanding < MAX_OUT) && !bus.flush_i;
    assign w_pop   = w_issue && bus.lo_ready_i;
    assign w_resp  = bus.lo_resp_valid_i && (r_outstanding != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_line[i] <= '0;
            end
            r_valid <= '0;
        end else if (bus.flush_i) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_tail == PW'(i))) begin
                    r_line[i]  <= w_in_line;
                    r_valid[i] <= 1'b1;
                end else if (w_pop && (r_head == PW'(i))) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // Issue can only happen below MAX_OUT, so the increment never overflows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outstanding <= '0;
            r_drop_dup    <= 1'b0;
            r_drop_full   <= 1'b0;
        end else begin
            if (w_pop && !w_resp)      r_outstanding <= r_outstanding + 1'b1;
            else if (!w_pop && w_resp) r_outstanding <= r_outstanding - 1'b1;
            r_drop_dup  <= w_req && w_dup;
            r_drop_full <= w_req && !w_dup && w_full;
        end
    end

    assign bus.lo_address_o  = {r_line[r_head], {LOGLINE{1'b0}}};
    assign bus.lo_valid_o    = w_issue;
    assign bus.drop_dup_o    = r_drop_dup;
    assign bus.drop_full_o   = r_drop_full;
    assign bus.occupancy_o   = r_count;
    assign bus.outstanding_o = r_outstanding;
endmodule
